// File: rtl/stream_arbiter_pkg.sv
// Shared types and helpers for the stream arbiter.
//   arb_state_t : ARB (free arbitration) / HOLD (grant locked to lock_id)
//   id_width()  : width of a requester index, at least 1 bit
//   rr_pick()   : behavioural round-robin pick over a valid vector, returning
//                 {found, index}; scans ptr+1, ptr+2, ... modulo n
package stream_arbiter_pkg;

  localparam int MAX_INPUTS = 64;
  localparam int MAX_ID_W   = 6;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] index;
  } rr_pick_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic rr_pick_t rr_pick(input logic [MAX_INPUTS-1:0] valid,
                                       input int n, input int ptr);
    rr_pick_t res;
    int j;
    res = '0;
    for (int k = 1; k <= n; k++) begin
      j = (ptr + k) % n;
      if (!res.found && valid[j[MAX_ID_W-1:0]]) begin
        res.found = 1'b1;
        res.index = j[MAX_ID_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_arbiter_if.sv
// Bundle of the N requester streams plus the single shared output stream.
//   w_valid/w_data/w_last : requester side, driven by the requesters
//   w_ready               : per-requester ready, driven by the arbiter
//   r_valid/r_data/r_last/r_id : shared output, driven by the arbiter
//   r_ready               : downstream ready, driven by the sink
// master = requesters + sink (the environment), slave = the arbiter.
interface stream_arbiter_if
  import stream_arbiter_pkg::*;
#(
  parameter type TYPE       = logic,
  parameter int  NUM_INPUTS = 2,
  parameter int  ID_WIDTH   = id_width(NUM_INPUTS)
);

  logic [NUM_INPUTS-1:0] w_valid;
  logic [NUM_INPUTS-1:0] w_ready;
  TYPE                   w_data [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] w_last;
  logic                  r_valid;
  logic                  r_ready;
  TYPE                   r_data;
  logic                  r_last;
  logic [ID_WIDTH-1:0]   r_id;

  modport master (
    output w_valid, w_data, w_last, r_ready,
    input  w_ready, r_valid, r_data, r_last, r_id
  );

  modport slave (
    input  w_valid, w_data, w_last, r_ready,
    output w_ready, r_valid, r_data, r_last, r_id
  );

endinterface

// File: rtl/stream_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so that the
// entry after ptr sits at bit 0, priority-encode the lowest set bit, then
// rotate the offset back into an absolute index (modulo N, so non-power-of-two
// N never yields an out-of-range index).
//   valid : request vector
//   ptr   : index of the previous winner
//   found : at least one request present
//   index : winning index (0 when nothing is requested)
module rr_picker #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);

  localparam int W1 = W + 1;

  logic [W-1:0]  start;
  logic [N-1:0]  rot;
  logic [W-1:0]  offset;
  logic [W1-1:0] sum;

  always_comb begin
    // Search begins one past the previous winner, wrapping at N-1.
    start  = (ptr >= W'(N - 1)) ? '0 : ptr + W'(1);
    rot    = N'({valid, valid} >> start);
    found  = |rot;
    offset = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) offset = W'(k);
    end
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= W1'(N)) sum = sum - W1'(N);
    index = found ? sum[W-1:0] : '0;
  end

endmodule

// File: rtl/stream_arbiter.sv
// N-to-1 round-robin stream arbiter onto one valid/ready sink.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : stream_arbiter_if slave modport (requester streams in, shared out)
// The selected requester drives the output combinationally. A grant is held
// while the output is stalled and, when PACKET=1, until a last beat transfers.
module stream_arbiter
  import stream_arbiter_pkg::*;
#(
  parameter type TYPE       = logic,
  parameter int  NUM_INPUTS = 2,
  parameter bit  PACKET     = 1'b0,
  parameter int  ID_WIDTH   = id_width(NUM_INPUTS)
) (
  input  logic            clk,
  input  logic            rst,
  stream_arbiter_if.slave bus
);

  if (NUM_INPUTS < 2) begin : g_bad_num_inputs
    $fatal(1, "stream_arbiter: NUM_INPUTS must be >= 2");
  end

  arb_state_t          state;
  logic [ID_WIDTH-1:0] prio_ptr;
  logic [ID_WIDTH-1:0] lock_id;

  logic                pick_found;
  logic [ID_WIDTH-1:0] pick_id;
  logic [ID_WIDTH-1:0] winner;
  logic                grant;
  logic                win_valid;
  logic                win_last;
  logic                xfer;
  TYPE                 win_data;

  rr_picker #(
    .N (NUM_INPUTS),
    .W (ID_WIDTH)
  ) u_rr_picker (
    .valid (bus.w_valid),
    .ptr   (prio_ptr),
    .found (pick_found),
    .index (pick_id)
  );

  always_comb begin
    if (state == HOLD) begin
      winner = lock_id;
      grant  = 1'b1;
    end else begin
      winner = pick_id;
      grant  = pick_found;
    end
    // Reset masks the handshake outputs regardless of requests.
    grant     = grant & ~rst;
    win_valid = bus.w_valid[winner] & ~rst;
    win_data  = bus.w_data[winner];
    win_last  = PACKET ? bus.w_last[winner] : 1'b1;
    xfer      = win_valid & bus.r_ready;
  end

  // In HOLD the locked requester keeps its ready even if it dropped valid, so
  // no other requester can sneak in while the lock is pending.
  always_comb begin
    bus.w_ready = '0;
    if (grant) bus.w_ready[winner] = bus.r_ready;
  end

  assign bus.r_valid = win_valid;
  assign bus.r_data  = win_data;
  assign bus.r_last  = win_last;
  assign bus.r_id    = winner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB;
      prio_ptr <= ID_WIDTH'(NUM_INPUTS - 1);
      lock_id  <= '0;
    end else if (xfer) begin
      prio_ptr <= winner;
      if (win_last) begin
        state <= ARB;
      end else begin
        state   <= HOLD;
        lock_id <= winner;
      end
    end else if (state == ARB && win_valid) begin
      // Stalled beat: freeze the choice so a later, higher-priority request
      // cannot change the presented beat before it is accepted.
      state   <= HOLD;
      lock_id <= winner;
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
module tb_stream_arbiter;

  typedef logic [7:0] byte_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stream_arbiter_if #(.TYPE(byte_t), .NUM_INPUTS(4), .ID_WIDTH(2)) if4 ();
  stream_arbiter_if #(.TYPE(byte_t), .NUM_INPUTS(3), .ID_WIDTH(2)) if3 ();
  stream_arbiter_if #(.TYPE(byte_t), .NUM_INPUTS(2), .ID_WIDTH(1)) if2 ();

  stream_arbiter #(.TYPE(byte_t), .NUM_INPUTS(4), .PACKET(1'b0), .ID_WIDTH(2)) u4 (
    .clk (clk), .rst (rst), .bus (if4)
  );
  stream_arbiter #(.TYPE(byte_t), .NUM_INPUTS(3), .PACKET(1'b0), .ID_WIDTH(2)) u3 (
    .clk (clk), .rst (rst), .bus (if3)
  );
  stream_arbiter #(.TYPE(byte_t), .NUM_INPUTS(2), .PACKET(1'b1), .ID_WIDTH(1)) u2 (
    .clk (clk), .rst (rst), .bus (if2)
  );

  int checks = 0;
  int errors = 0;
  int sb[$];

  typedef struct {
    logic [3:0] wv;
    logic       rr;
    logic       ev;
    logic [1:0] eid;
    logic [3:0] ewr;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic sb_pop(input string nm, input logic [31:0] act);
    logic [31:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s actual=%0h required=<nothing expected>", nm, act);
    end else begin
      exp = 32'(sb.pop_front());
      if (act !== exp) begin
        errors++;
        $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // Stall / idle / valid-drop sequence for the 4-input, per-beat arbiter.
    tbl[0]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
    tbl[1]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
    tbl[2]  = '{4'b0100, 1'b0, 1'b1, 2'd2, 4'b0000};
    tbl[3]  = '{4'b0101, 1'b0, 1'b1, 2'd2, 4'b0000};
    tbl[4]  = '{4'b0101, 1'b1, 1'b1, 2'd2, 4'b0100};
    tbl[5]  = '{4'b0101, 1'b1, 1'b1, 2'd0, 4'b0001};
    tbl[6]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[7]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[9]  = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000};
    tbl[11] = '{4'b1111, 1'b0, 1'b1, 2'd1, 4'b0000};
    tbl[12] = '{4'b1000, 1'b1, 1'b0, 2'd1, 4'b0010};
    tbl[13] = '{4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010};
    tbl[14] = '{4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000};

    rst = 1'b1;
    if4.w_valid = 4'b1111; if4.r_ready = 1'b1; if4.w_last = '0;
    if3.w_valid = '0;      if3.r_ready = 1'b0; if3.w_last = '0;
    if2.w_valid = '0;      if2.r_ready = 1'b0; if2.w_last = '0;
    for (int i = 0; i < 4; i++) if4.w_data[i] = 8'(8'hA0 + i);
    for (int i = 0; i < 3; i++) if3.w_data[i] = 8'(8'h30 + i);
    for (int i = 0; i < 2; i++) if2.w_data[i] = 8'(8'h20 + i);

    // Reset holds the outputs quiet even with every input requesting.
    @(negedge clk);
    chk("rst_r_valid", 32'(if4.r_valid), 32'd0);
    chk("rst_w_ready", 32'(if4.w_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Fairness, 4 inputs all requesting.
    for (int i = 0; i < 8; i++) sb.push_back(i % 4);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("fair4_onehot_c%0d", c), 32'($onehot(if4.w_ready)), 32'd1);
      if (if4.r_valid && if4.r_ready) sb_pop($sformatf("fair4_id_c%0d", c), 32'(if4.r_id));
      else chk($sformatf("fair4_xfer_c%0d", c), 32'(if4.r_valid & if4.r_ready), 32'd1);
    end
    chk("fair4_drain", 32'(sb.size()), 32'd0);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      if4.w_valid = tbl[i].wv;
      if4.r_ready = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("vec%0d_r_valid", i), 32'(if4.r_valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_r_id", i),    32'(if4.r_id),    32'(tbl[i].eid));
      chk($sformatf("vec%0d_w_ready", i), 32'(if4.w_ready), 32'(tbl[i].ewr));
      if (tbl[i].ev)
        chk($sformatf("vec%0d_r_data", i), 32'(if4.r_data), 32'(8'hA0) + 32'(tbl[i].eid));
    end

    // Non-power-of-two fairness, 3 inputs.
    @(posedge clk); #1;
    if4.w_valid = '0;
    if3.w_valid = 3'b111; if3.r_ready = 1'b1;
    for (int i = 0; i < 6; i++) sb.push_back(i % 3);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("fair3_range_c%0d", c), 32'(if3.r_id < 2'd3), 32'd1);
      if (if3.r_valid && if3.r_ready) sb_pop($sformatf("fair3_id_c%0d", c), 32'(if3.r_id));
      else chk($sformatf("fair3_xfer_c%0d", c), 32'(if3.r_valid & if3.r_ready), 32'd1);
    end
    chk("fair3_drain", 32'(sb.size()), 32'd0);

    // Packet mode: input 0 sends 3 beats while input 1 waits; entries are id*2+last.
    sb.push_back(0); sb.push_back(0); sb.push_back(1); sb.push_back(3);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if3.w_valid = '0;
      if2.w_valid = 2'b11; if2.r_ready = 1'b1;
      if2.w_last  = {1'b1, (c == 2)};
      @(negedge clk);
      if (if2.r_valid && if2.r_ready)
        sb_pop($sformatf("pkt_id_last_c%0d", c), 32'({if2.r_id, if2.r_last}));
      else chk($sformatf("pkt_xfer_c%0d", c), 32'(if2.r_valid & if2.r_ready), 32'd1);
    end
    chk("pkt_drain", 32'(sb.size()), 32'd0);

    // Lock input 1 mid-packet, then reset while locked.
    @(posedge clk); #1;
    if2.w_valid = 2'b10; if2.w_last = 2'b00;
    @(negedge clk);
    chk("hold_setup_id", 32'(if2.r_id), 32'd1);
    chk("hold_setup_last", 32'(if2.r_last), 32'd0);
    @(posedge clk); #1;
    if2.w_valid = 2'b11;
    @(negedge clk);
    chk("hold_keep_id", 32'(if2.r_id), 32'd1);
    chk("hold_keep_w_ready", 32'(if2.w_ready), 32'd2);
    chk("hold_keep_data", 32'(if2.r_data), 32'h21);
    @(posedge clk); #1;
    rst = 1'b1;
    if4.w_valid = 4'b1111;
    @(negedge clk);
    chk("midrst_r_valid", 32'(if2.r_valid), 32'd0);
    chk("midrst_w_ready", 32'(if2.w_ready), 32'd0);
    chk("midrst_u4_r_valid", 32'(if4.r_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_r_id", 32'(if2.r_id), 32'd0);
    chk("postrst_r_valid", 32'(if2.r_valid), 32'd1);
    chk("postrst_u4_r_id", 32'(if4.r_id), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_arbiter.md
Name: stream_arbiter

Overview:
- N-to-1 round-robin arbiter sharing one valid/ready stream sink (typically a shared fifo write port) between NUM_INPUTS requesters.
- Grant is held stable while the output is stalled, and optionally for a whole packet (until a beat with last=1 transfers).
- Zero-latency combinational path from the selected input to the output; all state is in the grant/lock registers.

Parameters:
- TYPE, logic, payload type of each beat.
- NUM_INPUTS, 2, number of requesters; must be >= 2 (static $fatal check otherwise).
- PACKET, 0, 1 = hold grant until a beat with last=1 transfers; 0 = re-arbitrate after every beat.
- ID_WIDTH, $clog2(NUM_INPUTS), width of r_id.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- w_valid  input  NUM_INPUTS  per-requester valid.
- w_ready  output  NUM_INPUTS  per-requester ready; one-hot or zero.
- w_data  input  TYPE [NUM_INPUTS]  per-requester payload.
- w_last  input  NUM_INPUTS  end-of-packet flag; ignored when PACKET=0.
- r_valid  output  1  output beat valid.
- r_ready  input  1  downstream ready.
- r_data  output  TYPE  payload of the granted requester.
- r_last  output  1  w_last of the granted requester; forced to 1 when PACKET=0.
- r_id  output  ID_WIDTH  index of the granted requester.

Behaviour:
- State registers:
  - prio_ptr: index of the last winner.
  - locked: 1 bit.
  - lock_id: ID_WIDTH bits.
- Reset (rst=1, asynchronous): prio_ptr = NUM_INPUTS-1 (input 0 has highest priority first), locked = 0, lock_id = 0.
- While rst=1, r_valid = 0 and w_ready = all zeros, regardless of inputs.
- Two states:
  - ARB (locked=0): winner = first i with w_valid[i]=1, scanning prio_ptr+1, prio_ptr+2, ... modulo NUM_INPUTS. No valid input gives r_valid=0 and r_id=0.
  - HOLD (locked=1): winner = lock_id, regardless of other valids.
- Outputs (combinational):
  - r_valid = w_valid[winner].
  - r_data = w_data[winner], r_id = winner.
  - w_ready[winner] = r_ready; w_ready of every other input = 0.
- Transfer = r_valid && r_ready. On a transfer:
  - prio_ptr <= winner.
  - If PACKET=1 and r_last=0: locked <= 1, lock_id <= winner.
  - If r_last=1: locked <= 0.
- Stall: in ARB with r_valid=1 and r_ready=0, locked <= 1 and lock_id <= winner. Output beat, r_id and r_data stay stable until the transfer; a higher-priority request arriving later does not preempt.
- After a stalled beat transfers with PACKET=0 (or r_last=1), locked returns to 0 and arbitration resumes the next cycle.
- Requester valid drop while in HOLD (protocol violation) is tolerated: r_valid=0, and the lock is kept until that requester transfers.
- Fairness: with all inputs continuously valid and r_ready=1, grant order is 0,1,...,N-1,0,... with exactly one beat (PACKET=0) or one packet (PACKET=1) each.
- Pointer wrap: prio_ptr+k is taken modulo NUM_INPUTS, correct for non-power-of-two N; no out-of-range index is ever produced.
- Reset asserted mid-packet: lock cleared immediately; after reset deasserts, the next arbitration starts from input 0.
- No combinational path from r_ready to r_valid. A path from w_valid to w_ready exists only through the winner selection.

Decomposition:
- Package stream_arbiter_pkg: function rr_pick(valid vector, pointer) returning {found, index}, plus a localparam helper for ID_WIDTH.
- Sub-module rr_picker: purely combinational rotate / priority-encode / unrotate with parameter N. It is instantiated once in stream_arbiter and is reusable by future schedulers.
- The lock/prio_ptr FSM stays in stream_arbiter.

Test Plan:
- N=4, PACKET=0, w_valid=4'b1111, r_ready=1 for 8 cycles -> r_id sequence 0,1,2,3,0,1,2,3; exactly one w_ready bit high each cycle.
- N=4, PACKET=0: w_valid=4'b0100, r_ready=0 for 3 cycles, then w_valid=4'b0101 -> r_id stays 2 with r_data unchanged until r_ready=1; next grant after the transfer is 0.
- N=3 (non-power-of-two), PACKET=0, all valid -> order 0,1,2,0,1,2; r_id never equals 3.
- N=2, PACKET=1: input0 sends 3 beats (last on the 3rd) while input1 is valid throughout -> r_id=0 for all 3 beats, then r_id=1; r_last=1 only on beat 3.
- Reset pulse on rst while in HOLD with lock_id=1 mid-packet -> same cycle r_valid=0 and w_ready=0; after release with w_valid=4'b0011, r_id=0.
- All w_valid=0 -> r_valid=0, w_ready=0, prio_ptr unchanged across 5 cycles; next single request on input 3 is granted the same cycle.
